bus_fabric: RTL and testbench

- Parametrised successor to the single-window RAM address decode used around generated C-to-HDL cores.
- Routes one master memory port (addr/size/valid/write/wdata/rdata/ready) to NSLV slave windows and subtracts each window's base address.
- Adds behaviour the fixed decode lacks: registered select, a wait-state timeout, an error response for unmapped or timed-out accesses, and an error counter.
- Sits between the generated core and RAM, stdio and peripheral slaves.

---
 rtl/bus_fabric_pkg.sv | 16 +
 rtl/bus_window_dec.sv | 31 +++
 rtl/bus_fabric.sv | 152 +++++++++++++++
 tb/tb_bus_fabric.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_fabric_pkg.sv
// Shared types and constants for the bus_fabric address decoder and router.
package bus_fabric_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StErr
    } state_t;

    localparam logic [31:0] DefErrData = 32'hDEADBEEF;

    localparam logic [2:0] SizeByte = 3'd0;
    localparam logic [2:0] SizeHalf = 3'd1;
    localparam logic [2:0] SizeWord = 3'd2;

endpackage

// File: rtl/bus_window_dec.sv
// Combinational window decoder: reports whether an address falls in any enabled window
// and the lowest matching window index.
module bus_window_dec
    import bus_fabric_pkg::*;
#(
    parameter int unsigned NSLV = 2,
    parameter int unsigned AW   = 32,
    parameter int unsigned SW   = 1
) (
    input  logic [AW-1:0]      addr,
    input  logic [NSLV*AW-1:0] base,
    input  logic [NSLV*AW-1:0] span,
    output logic               hit,
    output logic [SW-1:0]      idx
);

    // Walk downwards so the lowest matching window is the one left standing.
    // The offset is only formed once addr >= base, so it never wraps.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((addr >= base[i*AW +: AW]) &&
                ((addr - base[i*AW +: AW]) < span[i*AW +: AW])) begin
                hit = 1'b1;
                idx = SW'(i);
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// Routes one master memory port to NSLV slave windows with a registered select,
// wait-state timeout, error response for unmapped/timed-out accesses and an error counter.
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int unsigned        NSLV     = 2,
    parameter int unsigned        AW       = 32,
    parameter int unsigned        DW       = 32,
    parameter logic [NSLV*AW-1:0] BASE     = {32'h2000, 32'h1000},
    parameter logic [NSLV*AW-1:0] SPAN     = {32'h100, 32'h1000},
    parameter int unsigned        TIMEOUT  = 255,
    parameter logic [DW-1:0]      ERR_DATA = DW'(DefErrData)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AW-1:0]      m_addr,
    input  logic [2:0]         m_size,
    input  logic               m_valid,
    input  logic               m_write,
    input  logic [DW-1:0]      m_wdata,
    output logic [DW-1:0]      m_rdata,
    output logic               m_ready,
    output logic               m_err,
    output logic [AW-1:0]      s_addr,
    output logic [2:0]         s_size,
    output logic               s_write,
    output logic [DW-1:0]      s_wdata,
    output logic [NSLV-1:0]    s_valid,
    input  logic [NSLV*DW-1:0] s_rdata,
    input  logic [NSLV-1:0]    s_ready,
    output logic [15:0]        err_count
);

    localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    if ((NSLV < 1) || (NSLV > 8)) begin : g_nslv_check
        $error("bus_fabric: NSLV must be in 1..8");
    end

    state_t        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [15:0]   err_cnt_q, err_cnt_d;

    logic          dec_hit;
    logic [SW-1:0] dec_idx;

    logic [AW-1:0]   sel_base;
    logic [DW-1:0]   sel_rdata;
    logic            sel_ready;
    logic [NSLV-1:0] sel_onehot;

    bus_window_dec #(
        .NSLV(NSLV),
        .AW  (AW),
        .SW  (SW)
    ) u_dec (
        .addr(m_addr),
        .base(BASE),
        .span(SPAN),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    always_comb begin
        sel_base   = '0;
        sel_rdata  = '0;
        sel_ready  = 1'b0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (sel_q == SW'(i)) begin
                sel_base      = BASE[i*AW +: AW];
                sel_rdata     = s_rdata[i*DW +: DW];
                sel_ready     = s_ready[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign s_addr    = m_addr - sel_base;
    assign s_size    = m_size;
    assign s_write   = m_write;
    assign s_wdata   = m_wdata;
    assign err_count = err_cnt_q;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        tcnt_d    = tcnt_q;
        err_cnt_d = err_cnt_q;
        s_valid   = '0;
        m_ready   = 1'b0;
        m_err     = 1'b0;
        m_rdata   = '0;
        unique case (state_q)
            StIdle: begin
                if (m_valid) begin
                    if (dec_hit) begin
                        sel_d   = dec_idx;
                        tcnt_d  = '0;
                        state_d = StXfer;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StXfer: begin
                if (!m_valid) begin
                    // Master withdrew the request: silent abort, no response.
                    state_d = StIdle;
                end else begin
                    s_valid = sel_onehot;
                    if (sel_ready) begin
                        m_ready = 1'b1;
                        m_rdata = sel_rdata;
                        state_d = StIdle;
                    end else if ((TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT - 1))) begin
                        state_d = StErr;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            StErr: begin
                m_ready = 1'b1;
                m_err   = 1'b1;
                m_rdata = ERR_DATA;
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            tcnt_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            tcnt_q    <= tcnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_fabric.sv
// Bench for bus_fabric: directed cases then randomized transactions against a
// transaction-level reference model, on a default instance and an overlap/short-timeout one.
module tb_bus_fabric;
    import bus_fabric_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] m_addr, m_wdata;
    logic [2:0]  m_size;
    logic        m_write;
    logic        m_valid_a, m_valid_b;

    logic [31:0] m_rdata_a, m_rdata_b, s_addr_a, s_addr_b, s_wdata_a, s_wdata_b;
    logic        m_ready_a, m_ready_b, m_err_a, m_err_b, s_write_a, s_write_b;
    logic [2:0]  s_size_a, s_size_b;
    logic [1:0]  s_valid_a, s_valid_b, s_ready_a, s_ready_b;
    logic [63:0] s_rdata_a, s_rdata_b;
    logic [15:0] err_count_a, err_count_b;

    bus_fabric dut_a (
        .clk      (clk),
        .rst      (rst),
        .m_addr   (m_addr),
        .m_size   (m_size),
        .m_valid  (m_valid_a),
        .m_write  (m_write),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata_a),
        .m_ready  (m_ready_a),
        .m_err    (m_err_a),
        .s_addr   (s_addr_a),
        .s_size   (s_size_a),
        .s_write  (s_write_a),
        .s_wdata  (s_wdata_a),
        .s_valid  (s_valid_a),
        .s_rdata  (s_rdata_a),
        .s_ready  (s_ready_a),
        .err_count(err_count_a)
    );

    bus_fabric #(
        .BASE   ({32'h1800, 32'h1000}),
        .SPAN   ({32'h100, 32'h1000}),
        .TIMEOUT(4)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .m_addr   (m_addr),
        .m_size   (m_size),
        .m_valid  (m_valid_b),
        .m_write  (m_write),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata_b),
        .m_ready  (m_ready_b),
        .m_err    (m_err_b),
        .s_addr   (s_addr_b),
        .s_size   (s_size_b),
        .s_write  (s_write_b),
        .s_wdata  (s_wdata_b),
        .s_valid  (s_valid_b),
        .s_rdata  (s_rdata_b),
        .s_ready  (s_ready_b),
        .err_count(err_count_b)
    );

    // Currently addressed instance and its observed outputs.
    logic        cur;
    logic [31:0] o_rdata, o_s_addr, o_s_wdata;
    logic        o_ready, o_err, o_s_write;
    logic [2:0]  o_s_size;
    logic [1:0]  o_s_valid;
    logic [15:0] o_err_count;

    always_comb begin
        o_rdata     = cur ? m_rdata_b : m_rdata_a;
        o_ready     = cur ? m_ready_b : m_ready_a;
        o_err       = cur ? m_err_b : m_err_a;
        o_s_addr    = cur ? s_addr_b : s_addr_a;
        o_s_size    = cur ? s_size_b : s_size_a;
        o_s_write   = cur ? s_write_b : s_write_a;
        o_s_wdata   = cur ? s_wdata_b : s_wdata_a;
        o_s_valid   = cur ? s_valid_b : s_valid_a;
        o_err_count = cur ? err_count_b : err_count_a;
    end

    // Reference configuration and state.
    logic [31:0] base_m [2][2];
    logic [31:0] span_m [2][2];
    int          tmo_m  [2];
    int          exp_err[2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First window (lowest index) whose byte range contains the address.
    function automatic void ref_dec(input int d, input logic [31:0] a, output bit hit,
                                    output int idx);
        logic [63:0] a64, lo, hi;
        hit = 1'b0;
        idx = 0;
        a64 = {32'h0, a};
        for (int i = 0; i < 2; i++) begin
            lo = {32'h0, base_m[d][i]};
            hi = lo + {32'h0, span_m[d][i]};
            if (!hit && a64 >= lo && a64 < hi) begin
                hit = 1'b1;
                idx = i;
            end
        end
    endfunction

    task automatic set_valid(input logic v);
        if (cur) m_valid_b = v;
        else     m_valid_a = v;
    endtask

    task automatic drive_slave(input logic [1:0] rdy, input logic [63:0] rd);
        if (cur) begin
            s_ready_b = rdy;
            s_rdata_b = rd;
        end else begin
            s_ready_a = rdy;
            s_rdata_a = rd;
        end
    endtask

    task automatic bump_err(input int d);
        if (exp_err[d] < 65535) exp_err[d]++;
    endtask

    // One master transaction; slave answers after wait_n stalled XFER cycles.
    task automatic txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [2:0] sz, input int wait_n, input logic [31:0] rd);
        bit          hit;
        int          idx;
        int          tmo;
        logic [31:0] base;
        logic [1:0]  oh;
        logic [63:0] noise;
        ref_dec(cur, addr, hit, idx);
        tmo     = tmo_m[cur];
        m_addr  = addr;
        m_write = wr;
        m_wdata = wd;
        m_size  = sz;
        set_valid(1'b1);
        drive_slave(2'b00, {$urandom, $urandom});
        #1;
        chk("req_s_valid", o_s_valid, 2'b00);
        chk("req_m_ready", o_ready, 1'b0);
        @(negedge clk);
        if (!hit) begin
            drive_slave(2'b11, {$urandom, $urandom});
            #1;
            chk("miss_s_valid", o_s_valid, 2'b00);
            chk("miss_m_ready", o_ready, 1'b1);
            chk("miss_m_err", o_err, 1'b1);
            chk("miss_m_rdata", o_rdata, 32'hDEADBEEF);
            bump_err(cur);
        end else begin
            base = base_m[cur][idx];
            oh   = 2'b01 << idx;
            for (int j = 0; j < 2000; j++) begin
                noise = {$urandom, $urandom};
                if (tmo != 0 && j == tmo) begin
                    drive_slave(2'b00, noise);
                    #1;
                    chk("tmo_s_valid", o_s_valid, 2'b00);
                    chk("tmo_m_ready", o_ready, 1'b1);
                    chk("tmo_m_err", o_err, 1'b1);
                    chk("tmo_m_rdata", o_rdata, 32'hDEADBEEF);
                    bump_err(cur);
                    break;
                end
                chk("xfer_budget", (j < 1999), 1'b1);
                if (j == wait_n) begin
                    noise[idx*32 +: 32] = rd;
                    drive_slave(oh | (~oh & 2'($urandom)), noise);
                    #1;
                    chk("done_s_valid", o_s_valid, oh);
                    chk("done_s_addr", o_s_addr, addr - base);
                    chk("done_s_size", o_s_size, sz);
                    chk("done_s_write", o_s_write, wr);
                    chk("done_s_wdata", o_s_wdata, wd);
                    chk("done_m_ready", o_ready, 1'b1);
                    chk("done_m_err", o_err, 1'b0);
                    chk("done_m_rdata", o_rdata, rd);
                    break;
                end
                drive_slave(~oh & 2'($urandom), noise);
                #1;
                chk("wait_s_valid", o_s_valid, oh);
                chk("wait_s_addr", o_s_addr, addr - base);
                chk("wait_m_ready", o_ready, 1'b0);
                chk("wait_m_rdata", o_rdata, 32'h0);
                @(negedge clk);
            end
        end
        @(negedge clk);
        set_valid(1'b0);
        drive_slave(2'b00, 64'h0);
        #1;
        chk("idle_m_ready", o_ready, 1'b0);
        chk("idle_m_err", o_err, 1'b0);
        chk("idle_m_rdata", o_rdata, 32'h0);
        chk("idle_s_valid", o_s_valid, 2'b00);
        chk("err_count", o_err_count, 16'(exp_err[cur]));
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w;
        logic [31:0] a;
        base_m[0][0] = 32'h1000; span_m[0][0] = 32'h1000;
        base_m[0][1] = 32'h2000; span_m[0][1] = 32'h100;
        base_m[1][0] = 32'h1000; span_m[1][0] = 32'h1000;
        base_m[1][1] = 32'h1800; span_m[1][1] = 32'h100;
        tmo_m[0] = 255;
        tmo_m[1] = 4;
        exp_err[0] = 0;
        exp_err[1] = 0;
        cur = 1'b0;
        rst = 1'b1;
        m_addr = '0; m_wdata = '0; m_size = SizeWord; m_write = 1'b0;
        m_valid_a = 1'b0; m_valid_b = 1'b0;
        s_ready_a = '0; s_ready_b = '0; s_rdata_a = '0; s_rdata_b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cur = d[0];
            #1;
            chk("rst_m_ready", o_ready, 1'b0);
            chk("rst_s_valid", o_s_valid, 2'b00);
            chk("rst_err_count", o_err_count, 16'h0);
        end
        @(negedge clk);

        // Directed cases on the default instance.
        cur = 1'b0;
        txn(32'h1008, 1'b0, 32'h0, SizeWord, 1, 32'h00000005);
        txn(32'h2010, 1'b1, 32'hA5A5A5A5, SizeWord, 0, 32'h0);
        txn(32'h3000, 1'b0, 32'h0, SizeByte, 0, 32'h0);
        // Overlap/short-timeout instance.
        cur = 1'b1;
        txn(32'h1000, 1'b0, 32'h0, SizeHalf, 1000, 32'h0);
        txn(32'h1810, 1'b0, 32'h0, SizeWord, 2, 32'h12345678);
        txn(32'hFFFF_FFF0, 1'b0, 32'h0, SizeWord, 0, 32'h0);

        // Reset in the third XFER cycle.
        cur = 1'b0;
        m_addr = 32'h1000; m_write = 1'b0; m_size = SizeWord;
        set_valid(1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("pre_rst_s_valid", o_s_valid, 2'b01);
        @(negedge clk);
        rst = 1'b0;
        set_valid(1'b0);
        exp_err[0] = 0;
        exp_err[1] = 0;
        #1;
        chk("post_rst_s_valid", o_s_valid, 2'b00);
        chk("post_rst_m_ready", o_ready, 1'b0);
        chk("post_rst_err_count", o_err_count, 16'h0);
        chk("post_rst_err_count_b", err_count_b, 16'h0);
        @(negedge clk);
        txn(32'h1000, 1'b0, 32'h0, SizeWord, 0, 32'hCAFEF00D);

        // Randomized traffic on both instances.
        for (int k = 0; k < 60; k++) begin
            cur = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
            else                           a = 32'h0F80 + 32'($urandom_range(0, 32'h2100));
            w = $urandom_range(0, 6);
            if (cur && $urandom_range(0, 4) == 0) w = 1000;
            txn(a, 1'($urandom), $urandom, 3'($urandom_range(0, 2)), w, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
